// File: rtl/adc_uart_pkg.sv
// Shared types and constants for the ADC-to-UART hex line framer.
// Holds the line FSM states, the command/line-end ASCII codes and the nibble-to-ASCII helper.
package adc_uart_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIG  = 2'd1,
        CR   = 2'd2,
        LF   = 2'd3
    } state_t;

    localparam logic [7:0] CMD_START  = 8'h53;
    localparam logic [7:0] CMD_PAUSE  = 8'h50;
    localparam logic [7:0] CMD_RSTCNT = 8'h52;
    localparam logic [7:0] CHR_CR     = 8'h0D;
    localparam logic [7:0] CHR_LF     = 8'h0A;

    // Upper-case ASCII hex digit for one nibble.
    function automatic logic [7:0] nib2hex(input logic [3:0] nib);
        logic [7:0] chr;
        if (nib < 4'd10) begin
            chr = 8'h30 + {4'h0, nib};
        end else begin
            chr = 8'h37 + {4'h0, nib};
        end
        return chr;
    endfunction

endpackage

// File: rtl/adc_uart_framer.sv
// Turns ADC samples into "HHH\r\n" text lines on the UART TX FIFO and
// decodes single-byte run-control commands from the UART RX FIFO.
module adc_uart_framer
    import adc_uart_pkg::*;
#(
    parameter int   DW       = 12,
    parameter logic START_EN = 1'b0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          sample_valid,
    input  logic [DW-1:0] sample_data,
    input  logic          tx_full,
    output logic          wr_uart,
    output logic [7:0]    w_data,
    input  logic          rx_empty,
    input  logic [7:0]    r_data,
    output logic          rd_uart,
    output logic          streaming,
    output logic [7:0]    overrun_cnt
);

    localparam int NDIG = (DW + 3) / 4;
    localparam int SW   = NDIG * 4;
    localparam int KW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NDIG - 1);

    state_t          state_r;
    state_t          next_state_s;
    logic [DW-1:0]   hold_r;
    logic            hold_v_r;
    logic [SW-1:0]   sh_r;
    logic [KW-1:0]   k_r;
    logic            rd_block_r;
    logic            streaming_r;
    logic [7:0]      overrun_cnt_r;

    logic            load_s;
    logic            accept_s;
    logic            drop_s;
    logic            cmd_start_s;
    logic            cmd_pause_s;
    logic            cmd_rstcnt_s;

    assign streaming   = streaming_r;
    assign overrun_cnt = overrun_cnt_r;

    // Command pop pacing and decode; rd_block_r starts at 1 so nothing pops during reset.
    always_comb begin
        rd_uart      = ~rx_empty & ~rd_block_r;
        cmd_start_s  = rd_uart & (r_data == CMD_START);
        cmd_pause_s  = rd_uart & (r_data == CMD_PAUSE);
        cmd_rstcnt_s = rd_uart & (r_data == CMD_RSTCNT);
    end

    // Sample gate: the IDLE->DIG transfer frees the hold slot in the same cycle.
    always_comb begin
        accept_s = streaming_r & sample_valid & (~hold_v_r | load_s);
        drop_s   = streaming_r & sample_valid & hold_v_r & ~load_s;
    end

    // Line FSM next state and byte outputs.
    always_comb begin
        next_state_s = state_r;
        wr_uart      = 1'b0;
        w_data       = 8'h00;
        load_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (hold_v_r) begin
                    load_s       = 1'b1;
                    next_state_s = DIG;
                end else begin
                    next_state_s = IDLE;
                end
            end
            DIG: begin
                w_data  = nib2hex(sh_r[SW-1 -: 4]);
                wr_uart = ~tx_full;
                if (!tx_full && (k_r == K_LAST)) begin
                    next_state_s = CR;
                end else begin
                    next_state_s = DIG;
                end
            end
            CR: begin
                w_data  = CHR_CR;
                wr_uart = ~tx_full;
                if (!tx_full) begin
                    next_state_s = LF;
                end else begin
                    next_state_s = CR;
                end
            end
            LF: begin
                w_data  = CHR_LF;
                wr_uart = ~tx_full;
                if (!tx_full) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = LF;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // Line FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Digit shifter: the most significant nibble is always the one on the wire.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sh_r <= {SW{1'b0}};
            k_r  <= {KW{1'b0}};
        end else if (load_s) begin
            sh_r <= SW'(hold_r);
            k_r  <= {KW{1'b0}};
        end else if ((state_r == DIG) && wr_uart) begin
            sh_r <= sh_r << 3'd4;
            k_r  <= k_r + KW'(1);
        end else begin
            sh_r <= sh_r;
            k_r  <= k_r;
        end
    end

    // One-entry holding register; a pause discards any sample still waiting.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_r   <= {DW{1'b0}};
            hold_v_r <= 1'b0;
        end else begin
            if (accept_s) begin
                hold_r <= sample_data;
            end else begin
                hold_r <= hold_r;
            end
            if (cmd_pause_s) begin
                hold_v_r <= 1'b0;
            end else if (accept_s) begin
                hold_v_r <= 1'b1;
            end else if (load_s) begin
                hold_v_r <= 1'b0;
            end else begin
                hold_v_r <= hold_v_r;
            end
        end
    end

    // Run control: streaming enable, saturating drop counter (clear wins), pop pacing.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            streaming_r   <= START_EN;
            overrun_cnt_r <= 8'd0;
            rd_block_r    <= 1'b1;
        end else begin
            rd_block_r <= rd_uart;
            if (cmd_start_s) begin
                streaming_r <= 1'b1;
            end else if (cmd_pause_s) begin
                streaming_r <= 1'b0;
            end else begin
                streaming_r <= streaming_r;
            end
            if (cmd_rstcnt_s) begin
                overrun_cnt_r <= 8'd0;
            end else if (drop_s && (overrun_cnt_r != 8'hFF)) begin
                overrun_cnt_r <= overrun_cnt_r + 8'd1;
            end else begin
                overrun_cnt_r <= overrun_cnt_r;
            end
        end
    end

endmodule

// File: tb/tb_adc_uart_framer.sv
// Directed self-checking bench for adc_uart_framer (DW=12, START_EN=0)
// with a small RX FIFO model and a byte logger on the TX side.
module tb_adc_uart_framer;

    logic        clk = 1'b0;
    logic        reset;
    logic        sample_valid;
    logic [11:0] sample_data;
    logic        tx_full;
    logic        wr_uart;
    logic [7:0]  w_data;
    logic        rx_empty;
    logic [7:0]  r_data;
    logic        rd_uart;
    logic        streaming;
    logic [7:0]  overrun_cnt;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;

    logic [7:0] q_b[$];
    int         q_c[$];
    logic [7:0] rx_q[$];
    int         n_pop = 0;
    int         n_consec = 0;
    logic       prev_rd = 1'b0;
    logic       pop_pend = 1'b0;

    adc_uart_framer #(.DW(12), .START_EN(1'b0)) dut (
        .clk          (clk),
        .reset        (reset),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .tx_full      (tx_full),
        .wr_uart      (wr_uart),
        .w_data       (w_data),
        .rx_empty     (rx_empty),
        .r_data       (r_data),
        .rd_uart      (rd_uart),
        .streaming    (streaming),
        .overrun_cnt  (overrun_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Mid-cycle observation of written bytes and command pops.
    always @(negedge clk) begin
        if (wr_uart) begin
            q_b.push_back(w_data);
            q_c.push_back(cyc);
        end
        if (rd_uart && prev_rd) n_consec++;
        if (rd_uart) n_pop++;
        prev_rd  = rd_uart;
        pop_pend = rd_uart;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (pop_pend && (rx_q.size() > 0)) void'(rx_q.pop_front());
        rx_empty = (rx_q.size() == 0);
        r_data   = rx_empty ? 8'h00 : rx_q[0];
    endtask

    task automatic send_cmd(input logic [7:0] b);
        bit done;
        done = 1'b0;
        rx_q.push_back(b);
        rx_empty = 1'b0;
        r_data   = rx_q[0];
        for (int i = 0; (i < 8) && !done; i++) begin
            step();
            if (rx_q.size() == 0) done = 1'b1;
        end
        chk("cmd_pop", 32'(done), 32'd1);
    endtask

    task automatic chk_line(input string tag, input int base,
                            input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2);
        chk({tag, "_d0"}, 32'(q_b[base]),     32'(d0));
        chk({tag, "_d1"}, 32'(q_b[base + 1]), 32'(d1));
        chk({tag, "_d2"}, 32'(q_b[base + 2]), 32'(d2));
        chk({tag, "_cr"}, 32'(q_b[base + 3]), 32'h0D);
        chk({tag, "_lf"}, 32'(q_b[base + 4]), 32'h0A);
    endtask

    task automatic clr_log();
        q_b.delete();
        q_c.delete();
    endtask

    initial begin
        int t0;
        int p0;
        int c0;
        reset = 1'b0; sample_valid = 1'b0; sample_data = 12'h000;
        tx_full = 1'b0; rx_empty = 1'b1; r_data = 8'h00;
        #1;
        chk("rst_streaming", 32'(streaming), 32'd0);
        chk("rst_overrun",   32'(overrun_cnt), 32'd0);
        chk("rst_wr",        32'(wr_uart), 32'd0);
        chk("rst_wdata",     32'(w_data), 32'd0);
        chk("rst_rd",        32'(rd_uart), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        step(); step();

        // Start, one sample, exact byte timing
        send_cmd(8'h53);
        chk("start_streaming", 32'(streaming), 32'd1);
        clr_log();
        sample_valid = 1'b1; sample_data = 12'hA5C; t0 = cyc;
        step();
        sample_valid = 1'b0;
        repeat (8) step();
        chk("t1_len", 32'(q_b.size()), 32'd5);
        chk_line("t1", 0, 8'h41, 8'h35, 8'h43);
        for (int i = 0; i < 5; i++) chk("t1_cyc", 32'(q_c[i]), 32'(t0 + 2 + i));

        // Backpressure mid-digit
        clr_log();
        sample_valid = 1'b1; sample_data = 12'h3F7;
        step();
        sample_valid = 1'b0;
        step(); step();
        tx_full = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("bp_wr", 32'(wr_uart), 32'd0);
            chk("bp_wdata", 32'(w_data), 32'h46);
            step();
        end
        tx_full = 1'b0;
        repeat (8) step();
        chk("t2_len", 32'(q_b.size()), 32'd5);
        chk_line("t2", 0, 8'h33, 8'h46, 8'h37);

        // Overrun with samples one cycle apart
        clr_log();
        sample_valid = 1'b1; sample_data = 12'h111;
        step();
        sample_data = 12'h222;
        step();
        sample_data = 12'h333;
        step();
        sample_valid = 1'b0;
        repeat (20) step();
        chk("t3_len", 32'(q_b.size()), 32'd10);
        chk_line("t3a", 0, 8'h31, 8'h31, 8'h31);
        chk_line("t3b", 5, 8'h32, 8'h32, 8'h32);
        chk("t3_overrun", 32'(overrun_cnt), 32'd1);
        send_cmd(8'h52);
        chk("t3_rstcnt", 32'(overrun_cnt), 32'd0);

        // Saturation, then clear racing a drop
        tx_full = 1'b1; sample_valid = 1'b1; sample_data = 12'h5A5;
        repeat (310) step();
        chk("t3_sat", 32'(overrun_cnt), 32'd255);
        send_cmd(8'h52);
        sample_valid = 1'b0;
        #1;
        chk("t3_clr_wins", 32'(overrun_cnt), 32'd0);
        tx_full = 1'b0;
        repeat (20) step();

        // Pause while a second sample waits in hold
        clr_log();
        sample_valid = 1'b1; sample_data = 12'hABC;
        step();
        sample_valid = 1'b0;
        step();
        sample_valid = 1'b1; sample_data = 12'hDEF;
        step();
        sample_valid = 1'b0;
        send_cmd(8'h50);
        chk("t4_streaming", 32'(streaming), 32'd0);
        repeat (15) step();
        chk("t4_len", 32'(q_b.size()), 32'd5);
        chk_line("t4", 0, 8'h41, 8'h42, 8'h43);
        sample_valid = 1'b1; sample_data = 12'h777;
        repeat (3) step();
        sample_valid = 1'b0;
        repeat (10) step();
        chk("t4_len_after", 32'(q_b.size()), 32'd5);
        chk("t4_no_count", 32'(overrun_cnt), 32'd0);

        // Command pacing with four queued bytes
        p0 = n_pop; c0 = n_consec;
        rx_q.push_back(8'h58); rx_q.push_back(8'h53);
        rx_q.push_back(8'h51); rx_q.push_back(8'h50);
        rx_empty = 1'b0; r_data = rx_q[0];
        repeat (12) step();
        chk("t5_pops", 32'(n_pop - p0), 32'd4);
        chk("t5_consec", 32'(n_consec - c0), 32'd0);
        chk("t5_streaming", 32'(streaming), 32'd0);
        chk("t5_rx_drained", 32'(rx_q.size()), 32'd0);

        // Asynchronous reset mid-line
        send_cmd(8'h53);
        clr_log();
        sample_valid = 1'b1; sample_data = 12'h123;
        step();
        sample_valid = 1'b0;
        step(); step();
        #1;
        chk("t6_pre_wr", 32'(wr_uart), 32'd1);
        reset = 1'b0;
        #1;
        chk("t6_rst_wr", 32'(wr_uart), 32'd0);
        chk("t6_rst_wdata", 32'(w_data), 32'd0);
        chk("t6_rst_streaming", 32'(streaming), 32'd0);
        step(); step();
        reset = 1'b1;
        clr_log();
        repeat (10) step();
        chk("t6_no_bytes", 32'(q_b.size()), 32'd0);
        chk("t6_streaming", 32'(streaming), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
